// File: rtl/ddr_urgency_pkg.sv
// ddr_urgency_pkg: shared state type, limits and threshold helper
// for the DDR fabric-urgency controller.
package ddr_urgency_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        URGENT   = 2'd1,
        COOLDOWN = 2'd2
    } urg_state_e;

    localparam int LEVEL_MAX = 32;
    localparam int LAT_MAX   = 32;
    localparam int HOLD_MAX  = 32;

    // Release level forced strictly below the assert level.
    function automatic logic [LEVEL_MAX-1:0] lo_eff_calc(
        input logic [LEVEL_MAX-1:0] hi,
        input logic [LEVEL_MAX-1:0] lo
    );
        logic [LEVEL_MAX-1:0] r;
        if (hi == '0) begin
            r = '0;
        end else if (lo < hi) begin
            r = lo;
        end else begin
            r = hi - LEVEL_MAX'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_urgency_chan.sv
// ddr_urgency_chan: one port's wait counter, hold counter and
// IDLE/URGENT/COOLDOWN state machine.
module ddr_urgency_chan
    import ddr_urgency_pkg::*;
#(
    parameter int LEVEL_W = 8,
    parameter int LAT_W   = 12,
    parameter int HOLD_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               pending,
    input  logic [LEVEL_W-1:0] fill,
    input  logic [LEVEL_W-1:0] hi_thresh,
    input  logic [LEVEL_W-1:0] lo_thresh,
    input  logic [LAT_W-1:0]   timeout,
    input  logic [HOLD_W-1:0]  hold_cycles,
    input  logic               grant,
    output logic               want,
    output logic               arb,
    output logic               arb_nxt
);

    urg_state_e state_q, state_d;
    logic [LAT_W-1:0]   wait_q, wait_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               arb_q;
    logic [LEVEL_W-1:0] lo_eff;
    logic [HOLD_W-1:0]  hold_dec;
    logic               fill_hit;
    logic               to_hit;
    logic               trigger;
    logic               release_ok;
    logic               hold_done;

    always_comb begin
        lo_eff     = LEVEL_W'(lo_eff_calc(LEVEL_MAX'(hi_thresh),
                                          LEVEL_MAX'(lo_thresh)));
        fill_hit   = (fill >= hi_thresh);
        to_hit     = (timeout != '0) && (wait_q >= timeout);
        trigger    = fill_hit || to_hit;
        release_ok = (fill <= lo_eff) && !to_hit;
        hold_dec   = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
        // Expiry is judged on the post-decrement count, so hold_cycles
        // urgent cycles are guaranteed (at least one).
        hold_done  = (hold_dec == '0);
        want       = enable &&
                     (((state_q == IDLE) && trigger) ||
                      ((state_q == COOLDOWN) && fill_hit));
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!pending) begin
            wait_d = '0;
        end else if (wait_q == '1) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + LAT_W'(1);
        end
        if (!enable) begin
            state_d = IDLE;
            hold_d  = '0;
            wait_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trigger && grant) begin
                        state_d = URGENT;
                        hold_d  = hold_cycles;
                    end
                end
                URGENT: begin
                    hold_d = hold_dec;
                    if (hold_done && release_ok) begin
                        state_d = COOLDOWN;
                        hold_d  = hold_cycles;
                    end
                end
                COOLDOWN: begin
                    if (fill_hit && grant) begin
                        state_d = URGENT;
                        hold_d  = hold_cycles;
                    end else if (hold_done) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_dec;
                    end
                end
                default: begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            endcase
        end
        arb_nxt = (state_d == URGENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            hold_q  <= '0;
            arb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            arb_q   <= arb_nxt;
        end
    end

    assign arb = arb_q;

endmodule

// File: rtl/ddr_urgency_ctrl.sv
// ddr_urgency_ctrl: per-port DDR ARB urgency with capped ascending grants.
// Optional per-port urgent-cycle counters under DDR_URGENCY_STATS_EN.
module ddr_urgency_ctrl
    import ddr_urgency_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int LEVEL_W    = 8,
    parameter int LAT_W      = 12,
    parameter int HOLD_W     = 8,
    parameter int MAX_URGENT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_PORTS-1:0]         pending,
    input  logic [NUM_PORTS*LEVEL_W-1:0] fill,
    input  logic [LEVEL_W-1:0]           hi_thresh,
    input  logic [LEVEL_W-1:0]           lo_thresh,
    input  logic [LAT_W-1:0]             timeout,
    input  logic [HOLD_W-1:0]            hold_cycles,
`ifdef DDR_URGENCY_STATS_EN
    input  logic                         stat_clr,
    output logic [NUM_PORTS*32-1:0]      urgent_cycles,
`endif
    output logic [NUM_PORTS-1:0]         arb,
    output logic                         urgent_any
);

    logic [NUM_PORTS-1:0] want;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] arb_bits;
    logic [NUM_PORTS-1:0] arb_nxt;
    logic                 urgent_any_q, urgent_any_d;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
        ddr_urgency_chan #(
            .LEVEL_W (LEVEL_W),
            .LAT_W   (LAT_W),
            .HOLD_W  (HOLD_W)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .enable      (enable),
            .pending     (pending[i]),
            .fill        (fill[i*LEVEL_W +: LEVEL_W]),
            .hi_thresh   (hi_thresh),
            .lo_thresh   (lo_thresh),
            .timeout     (timeout),
            .hold_cycles (hold_cycles),
            .grant       (grant[i]),
            .want        (want[i]),
            .arb         (arb_bits[i]),
            .arb_nxt     (arb_nxt[i])
        );
    end

    // Slots come from this cycle's URGENT count, so a release frees
    // its slot only for the following cycle.
    always_comb begin : grant_logic
        int busy;
        int slots;
        busy = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            busy += int'(arb_bits[i]);
        end
        slots = MAX_URGENT - busy;
        grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (want[i] && (slots > 0)) begin
                grant[i] = 1'b1;
                slots    = slots - 1;
            end
        end
    end

    always_comb begin
        urgent_any_d = |arb_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            urgent_any_q <= 1'b0;
        end else begin
            urgent_any_q <= urgent_any_d;
        end
    end

    assign arb        = arb_bits;
    assign urgent_any = urgent_any_q;

`ifdef DDR_URGENCY_STATS_EN
    logic [31:0] cnt_q [NUM_PORTS];
    logic [31:0] cnt_d [NUM_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clr) begin
                cnt_d[i] = '0;
            end else if (arb_bits[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            urgent_cycles[i*32 +: 32] = cnt_q[i];
        end
    end
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_ddr_urgency_ctrl.sv
// tb_ddr_urgency_ctrl: vector table plus scoreboarded sequences
// for hysteresis, timeout, hold, cap, enable and reset.
module tb_ddr_urgency_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  pending;
    logic [31:0] fill;
    logic [7:0]  hi_thresh;
    logic [7:0]  lo_thresh;
    logic [11:0] timeout;
    logic [7:0]  hold_cycles;
    logic [3:0]  arb;
    logic        urgent_any;
`ifdef DDR_URGENCY_STATS_EN
    logic         stat_clr;
    logic [127:0] urgent_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] arb;
        string      nm;
    } exp_t;

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] f0;
        logic [3:0] exp;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[12];

    ddr_urgency_ctrl #(
        .NUM_PORTS  (4),
        .LEVEL_W    (8),
        .LAT_W      (12),
        .HOLD_W     (8),
        .MAX_URGENT (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pending     (pending),
        .fill        (fill),
        .hi_thresh   (hi_thresh),
        .lo_thresh   (lo_thresh),
        .timeout     (timeout),
        .hold_cycles (hold_cycles),
`ifdef DDR_URGENCY_STATS_EN
        .stat_clr      (stat_clr),
        .urgent_cycles (urgent_cycles),
`endif
        .arb         (arb),
        .urgent_any  (urgent_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_fill(input logic [7:0] f0, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [7:0] f3);
        fill = {f3, f2, f1, f0};
    endtask

    task automatic cyc(input logic [3:0] e, input string nm);
        exp_t x;
        exp_t y;
        x.arb = e;
        x.nm  = nm;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            y = sbq.pop_front();
            chk({y.nm, "/arb"}, 32'(arb), 32'(y.arb));
            chk({y.nm, "/any"}, 32'(urgent_any), 32'(|y.arb));
        end
    endtask

    initial begin
        vt[0]  = '{8'd200, 8'd100, 8'd150, 4'b0000};
        vt[1]  = '{8'd200, 8'd100, 8'd180, 4'b0000};
        vt[2]  = '{8'd200, 8'd100, 8'd200, 4'b0001};
        vt[3]  = '{8'd200, 8'd100, 8'd150, 4'b0001};
        vt[4]  = '{8'd200, 8'd100, 8'd101, 4'b0001};
        vt[5]  = '{8'd200, 8'd100, 8'd100, 4'b0000};
        vt[6]  = '{8'd200, 8'd100, 8'd100, 4'b0000};
        vt[7]  = '{8'd200, 8'd100, 8'd199, 4'b0000};
        vt[8]  = '{8'd200, 8'd250, 8'd200, 4'b0001};
        vt[9]  = '{8'd200, 8'd250, 8'd199, 4'b0000};
        vt[10] = '{8'd200, 8'd250, 8'd0,   4'b0000};
        vt[11] = '{8'd200, 8'd100, 8'd0,   4'b0000};

        rst_n       = 1'b0;
        enable      = 1'b1;
        pending     = '0;
        fill        = '0;
        hi_thresh   = 8'd200;
        lo_thresh   = 8'd100;
        timeout     = '0;
        hold_cycles = '0;
`ifdef DDR_URGENCY_STATS_EN
        stat_clr    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_arb", 32'(arb), 32'd0);
        chk("reset_any", 32'(urgent_any), 32'd0);
        rst_n = 1'b1;

        // Hysteresis and lo_eff clamp
        for (int i = 0; i < 12; i++) begin
            hi_thresh = vt[i].hi;
            lo_thresh = vt[i].lo;
            set_fill(vt[i].f0, 8'd0, 8'd0, 8'd0);
            cyc(vt[i].exp, $sformatf("t1_vec%0d", i));
        end
        lo_thresh = 8'd100;

        // Timeout on port 2
        timeout = 12'd50;
        pending = 4'b0100;
        for (int i = 0; i < 50; i++) cyc(4'b0000, "t2_wait");
        cyc(4'b0100, "t2_to_rise");
        cyc(4'b0100, "t2_to_stay");
        pending = 4'b0000;
        cyc(4'b0100, "t2_drop_lag");
        cyc(4'b0000, "t2_release");
        timeout = 12'd0;
        pending = 4'b0100;
        for (int i = 0; i < 80; i++) cyc(4'b0000, "t2_to_disabled");
        pending = 4'b0000;
        cyc(4'b0000, "t2_idle");

        // Hold, cooldown, timeout ignored, fill override
        hold_cycles = 8'd10;
        cyc(4'b0000, "t3_idle");
        set_fill(8'd200, 8'd0, 8'd0, 8'd0);
        cyc(4'b0001, "t3_spike");
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 9; i++) cyc(4'b0001, "t3_hold");
        cyc(4'b0000, "t3_cool");
        pending = 4'b0001;
        timeout = 12'd3;
        for (int i = 0; i < 10; i++) cyc(4'b0000, "t3_to_in_cool");
        cyc(4'b0001, "t3_to_after_cool");
        pending = 4'b0000;
        timeout = 12'd0;
        for (int i = 0; i < 9; i++) cyc(4'b0001, "t3_hold2");
        cyc(4'b0000, "t3_cool2");
        cyc(4'b0000, "t3_cool2b");
        cyc(4'b0000, "t3_cool2c");
        set_fill(8'd200, 8'd0, 8'd0, 8'd0);
        cyc(4'b0001, "t3_fill_override");
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 9; i++) cyc(4'b0001, "t3_hold3");
        for (int i = 0; i < 11; i++) cyc(4'b0000, "t3_cool3");
        hold_cycles = 8'd0;

        // Cap of two concurrent urgents
        set_fill(8'd200, 8'd200, 8'd200, 8'd200);
        cyc(4'b0011, "t4_cap");
        cyc(4'b0011, "t4_cap_hold");
        set_fill(8'd100, 8'd200, 8'd200, 8'd200);
        cyc(4'b0010, "t4_rel0");
        cyc(4'b0110, "t4_slot_reuse");
        cyc(4'b0110, "t4_steady");
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        cyc(4'b0000, "t4_rel_all");
        cyc(4'b0000, "t4_idle");

        // Enable clears state and wait counters
        set_fill(8'd0, 8'd200, 8'd0, 8'd200);
        pending = 4'b0001;
        for (int i = 0; i < 6; i++) cyc(4'b1010, "t5_1010");
        enable = 1'b0;
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        cyc(4'b0000, "t5_disable");
        cyc(4'b0000, "t5_disabled");
        enable  = 1'b1;
        timeout = 12'd5;
        for (int i = 0; i < 5; i++) cyc(4'b0000, "t5_no_residual");
        cyc(4'b0001, "t5_to_clean");
        pending = 4'b0000;
        cyc(4'b0001, "t5_drop_lag");
        cyc(4'b0000, "t5_release");
        timeout = 12'd0;
        cyc(4'b0000, "t5_idle");

        // Asynchronous reset mid-URGENT
        set_fill(8'd200, 8'd0, 8'd0, 8'd0);
        cyc(4'b0001, "t5_pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_arb", 32'(arb), 32'd0);
        chk("t5_async_any", 32'(urgent_any), 32'd0);
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        cyc(4'b0000, "t5_in_rst");
        rst_n = 1'b1;
        cyc(4'b0000, "t5_post_rst");
        set_fill(8'd200, 8'd0, 8'd0, 8'd0);
        cyc(4'b0001, "t5_recover");
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        cyc(4'b0000, "t5_rel");
        cyc(4'b0000, "t5_idle2");

`ifdef DDR_URGENCY_STATS_EN
        hold_cycles = 8'd37;
        stat_clr = 1'b1;
        cyc(4'b0000, "t6_clr");
        stat_clr = 1'b0;
        chk("t6_cnt1_cleared", urgent_cycles[32 +: 32], 32'd0);
        set_fill(8'd0, 8'd200, 8'd0, 8'd0);
        cyc(4'b0010, "t6_spike");
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 36; i++) cyc(4'b0010, "t6_hold");
        cyc(4'b0000, "t6_cool");
        chk("t6_cnt1_37", urgent_cycles[32 +: 32], 32'd37);
        chk("t6_cnt0_0", urgent_cycles[0 +: 32], 32'd0);
        for (int i = 0; i < 38; i++) cyc(4'b0000, "t6_cool_wait");
        set_fill(8'd0, 8'd200, 8'd0, 8'd0);
        cyc(4'b0010, "t6_spike2");
        set_fill(8'd0, 8'd0, 8'd0, 8'd0);
        cyc(4'b0010, "t6_hold2a");
        cyc(4'b0010, "t6_hold2b");
        chk("t6_cnt1_2", urgent_cycles[32 +: 32], 32'd2);
        stat_clr = 1'b1;
        cyc(4'b0010, "t6_clr_hi");
        chk("t6_clr_wins", urgent_cycles[32 +: 32], 32'd0);
        stat_clr = 1'b0;
        cyc(4'b0010, "t6_after_clr");
        chk("t6_count_resume", urgent_cycles[32 +: 32], 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
